// File: rtl/param_shift_register_if.sv
// Control, serial and parallel signals of the universal shift register.
// master drives the controls and data; slave is the register.
interface param_shift_register_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             i_ena;
  logic             i_leri;
  logic [1:0]       i_mode;
  logic             i_in;
  logic [WIDTH-1:0] i_par_in;
  logic             o_out;
  logic [WIDTH-1:0] o_q;
  logic [CW-1:0]    o_cnt;
  logic             o_done;

  modport master (
    output i_ena, i_leri, i_mode, i_in, i_par_in,
    input  o_out, o_q, o_cnt, o_done
  );

  modport slave (
    input  i_ena, i_leri, i_mode, i_in, i_par_in,
    output o_out, o_q, o_cnt, o_done
  );
endinterface

// File: rtl/param_shift_register.sv
// Universal shift register: hold/shift/rotate/load, saturating shift counter and frame-done pulse.
// Every output is a flop updated one edge after the operation; there is no backpressure, ena=0 freezes state.
module param_shift_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic                   clk,
  input logic                   rst,
  param_shift_register_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_ROT   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_out;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_out_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_done_nxt;
  logic             w_exit_bit;
  logic             w_fill_bit;
  mode_e            w_mode;

  assign w_mode     = mode_e'(bus.i_mode);
  assign w_exit_bit = bus.i_leri ? r_q[WIDTH-1] : r_q[0];
  // A rotate refills the vacated end with the bit that just left the other end.
  assign w_fill_bit = (w_mode == MODE_SHIFT) ? bus.i_in : w_exit_bit;

  always_comb begin
    w_q_nxt    = r_q;
    w_out_nxt  = r_out;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    if (bus.i_ena) begin
      case (w_mode)
        MODE_SHIFT, MODE_ROT: begin
          if (bus.i_leri) begin
            w_q_nxt = {r_q[WIDTH-2:0], w_fill_bit};
          end else begin
            w_q_nxt = {w_fill_bit, r_q[WIDTH-1:1]};
          end
          w_out_nxt = w_exit_bit;
          if (r_cnt != CNT_FULL) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
          w_done_nxt = (r_cnt == CNT_LAST);
        end
        MODE_LOAD: begin
          w_q_nxt   = bus.i_par_in;
          w_cnt_nxt = '0;
        end
        default: begin
          w_q_nxt = r_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= RESET_VALUE;
      r_out  <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_out  <= w_out_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign bus.o_q    = r_q;
  assign bus.o_out  = r_out;
  assign bus.o_cnt  = r_cnt;
  assign bus.o_done = r_done;
endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register (WIDTH=8): directed vector table, corner sequences and a randomized run against a value-level model.
module tb_param_shift_register;
  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'h00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_shift_register_if #(.WIDTH(W)) bus();
  param_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int m_q, m_out, m_cnt, m_done;

  typedef struct {
    string      name;
    logic       rst;
    logic       ena;
    logic       leri;
    logic [1:0] mode;
    logic       sin;
    logic [7:0] par;
    logic [7:0] q;
    logic       out;
    logic [3:0] cnt;
    logic       done;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // Register held as a plain integer; shifts are multiply/divide by two.
  task automatic model_step(input logic r, input logic e, input logic l, input logic [1:0] m,
                            input logic i, input logic [W-1:0] p);
    int mask, exitb, fill;
    mask = (1 << W) - 1;
    if (r) begin
      m_q = int'(RV); m_out = 0; m_cnt = 0; m_done = 0;
    end else if (!e || m == 2'b00) begin
      m_done = 0;
    end else if (m == 2'b11) begin
      m_q = int'(p); m_cnt = 0; m_done = 0;
    end else begin
      exitb  = l ? (m_q >> (W - 1)) & 1 : m_q & 1;
      fill   = (m == 2'b01) ? int'(i) : exitb;
      m_q    = l ? ((m_q * 2) + fill) & mask : (m_q / 2) + fill * (1 << (W - 1));
      m_out  = exitb;
      m_done = (m_cnt == W - 1) ? 1 : 0;
      m_cnt  = (m_cnt < W) ? m_cnt + 1 : W;
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic l, input logic [1:0] m,
                       input logic i, input logic [W-1:0] p);
    rst = r; bus.i_ena = e; bus.i_leri = l; bus.i_mode = m; bus.i_in = i; bus.i_par_in = p;
    @(posedge clk);
    #1;
    model_step(r, e, l, m, i, p);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_q"},    bus.o_q,    m_q);
    chk({tag, "_out"},  bus.o_out,  m_out);
    chk({tag, "_cnt"},  bus.o_cnt,  m_cnt);
    chk({tag, "_done"}, bus.o_done, m_done);
  endtask

  task automatic tick(input string tag, input logic r, input logic e, input logic l,
                      input logic [1:0] m, input logic i, input logic [W-1:0] p);
    drive(r, e, l, m, i, p);
    check_model(tag);
  endtask

  initial begin
    logic [7:0] bits;
    logic [7:0] snap_q;
    logic       snap_out;
    logic [3:0] snap_cnt;
    int         done_seen;

    rst = 1'b1; bus.i_ena = 1'b0; bus.i_leri = 1'b0; bus.i_mode = 2'b00;
    bus.i_in = 1'b0; bus.i_par_in = '0;
    @(negedge clk);

    //          name        rst  ena  leri mode   in   par    q      out  cnt  done
    vecs[0] = '{"reset",    1'b1,1'b1,1'b1,2'b01,1'b1,8'h00, 8'h00, 1'b0,4'd0,1'b0};
    vecs[1] = '{"load_a",   1'b0,1'b1,1'b0,2'b11,1'b0,8'hA5, 8'hA5, 1'b0,4'd0,1'b0};
    vecs[2] = '{"rotl",     1'b0,1'b1,1'b1,2'b10,1'b0,8'h00, 8'h4B, 1'b1,4'd1,1'b0};
    vecs[3] = '{"load_b",   1'b0,1'b1,1'b0,2'b11,1'b0,8'hA5, 8'hA5, 1'b1,4'd0,1'b0};
    vecs[4] = '{"rotr",     1'b0,1'b1,1'b0,2'b10,1'b1,8'h00, 8'hD2, 1'b1,4'd1,1'b0};
    vecs[5] = '{"load_c",   1'b0,1'b1,1'b0,2'b11,1'b0,8'hA5, 8'hA5, 1'b1,4'd0,1'b0};
    vecs[6] = '{"shl0",     1'b0,1'b1,1'b1,2'b01,1'b0,8'h00, 8'h4A, 1'b1,4'd1,1'b0};
    vecs[7] = '{"hold",     1'b0,1'b1,1'b1,2'b00,1'b1,8'hFF, 8'h4A, 1'b1,4'd1,1'b0};
    vecs[8] = '{"ena_off",  1'b0,1'b0,1'b1,2'b01,1'b1,8'hFF, 8'h4A, 1'b1,4'd1,1'b0};
    vecs[9] = '{"shr1",     1'b0,1'b1,1'b0,2'b01,1'b1,8'h00, 8'hA5, 1'b0,4'd2,1'b0};

    for (int k = 0; k < 10; k++) begin
      drive(vecs[k].rst, vecs[k].ena, vecs[k].leri, vecs[k].mode, vecs[k].sin, vecs[k].par);
      chk({vecs[k].name, "_q"},    bus.o_q,    vecs[k].q);
      chk({vecs[k].name, "_out"},  bus.o_out,  vecs[k].out);
      chk({vecs[k].name, "_cnt"},  bus.o_cnt,  vecs[k].cnt);
      chk({vecs[k].name, "_done"}, bus.o_done, vecs[k].done);
    end

    // Serial stream: 8 bits in, then 8 zeros push them back out MSB-first.
    bits = 8'b1011_0010;
    tick("s3_rst", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick("s3_in", 1'b0, 1'b1, 1'b1, 2'b01, bits[7-i], 8'h00);
      chk("s3_in_cnt", bus.o_cnt, i + 1);
      chk("s3_in_done", bus.o_done, (i == 7) ? 1 : 0);
      if (bus.o_done === 1'b1) done_seen++;
    end
    chk("s3_q_full", bus.o_q, 8'hB2);
    chk("s3_done_pulses", done_seen, 1);
    for (int i = 0; i < 8; i++) begin
      tick("s3_out", 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 8'h00);
      chk("s3_out_bit", bus.o_out, bits[7-i]);
      chk("s3_out_cnt", bus.o_cnt, 8);
      chk("s3_out_done", bus.o_done, 0);
    end

    // Rotate right a full circle and one beyond.
    tick("s4_load", 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 8'h3C);
    for (int i = 0; i < 8; i++) begin
      tick("s4_rot", 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 8'h00);
      chk("s4_rot_done", bus.o_done, (i == 7) ? 1 : 0);
    end
    chk("s4_q_circle", bus.o_q, 8'h3C);
    tick("s4_rot9", 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 8'h00);
    chk("s4_q_9th", bus.o_q, 8'h1E);
    chk("s4_cnt_9th", bus.o_cnt, 8);
    chk("s4_done_9th", bus.o_done, 0);

    // Enable gating at cnt=5.
    tick("s5_rst", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++)
      tick("s5_pre", 1'b0, 1'b1, 1'b1, 2'b01, 1'($urandom_range(0, 1)), 8'h00);
    chk("s5_cnt5", bus.o_cnt, 5);
    snap_q = bus.o_q; snap_out = bus.o_out; snap_cnt = bus.o_cnt;
    for (int i = 0; i < 3; i++) begin
      tick("s5_off", 1'b0, 1'b0, 1'b1, 2'b01, 1'($urandom_range(0, 1)), 8'hFF);
      chk("s5_off_q", bus.o_q, snap_q);
      chk("s5_off_out", bus.o_out, snap_out);
      chk("s5_off_cnt", bus.o_cnt, snap_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick("s5_post", 1'b0, 1'b1, 1'b1, 2'b01, 1'($urandom_range(0, 1)), 8'h00);
      chk("s5_post_done", bus.o_done, (i == 2) ? 1 : 0);
    end
    chk("s5_cnt8", bus.o_cnt, 8);

    // Reset at cnt=7, then a clean frame.
    tick("s6_rst", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++)
      tick("s6_pre", 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 8'h00);
    chk("s6_cnt7", bus.o_cnt, 7);
    tick("s6_mid_rst", 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 8'h00);
    chk("s6_rst_q", bus.o_q, RV);
    chk("s6_rst_cnt", bus.o_cnt, 0);
    chk("s6_rst_done", bus.o_done, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick("s6_post", 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 8'h00);
      if (bus.o_done === 1'b1) done_seen++;
    end
    chk("s6_done_pulses", done_seen, 1);

    for (int n = 0; n < 600; n++) begin
      tick("rnd",
           1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
